ui_input_debounce_bank: RTL

Parametrised, multi-channel successor to the single-wire trigger smoother. It replaces the per-button smoother instances with one bank of N channels. Each channel synchronises a raw GPIO input, debounces it over a configurable time, and produces four outputs: a clean active-high level, one-cycle press/release pulses, and a long-hold pulse. Sits between the board GPIO pins and the state controller, music-key controller and recording logic.

---
 rtl/ui_input_pkg.sv | 30 +++
 rtl/ui_debounce_channel.sv | 189 ++++++++++++++++++
 rtl/ui_input_debounce_bank.sv | 92 +++++++++
 3 files changed

// File: rtl/ui_input_pkg.sv
// Shared definitions for the UI input debounce bank: channel indices,
// the per-channel debounce state type and a counter-width helper.
package ui_input_pkg;

    // Board channel assignment
    localparam int UI_KEY0          = 0;
    localparam int UI_KEY1          = 1;
    localparam int UI_KEY2          = 2;
    localparam int UI_KEY3          = 3;
    localparam int UI_KEY4          = 4;
    localparam int UI_KEY5          = 5;
    localparam int UI_PLAYSONG0     = 6;
    localparam int UI_PLAYSONG1     = 7;
    localparam int UI_MAKERECORDING = 8;
    localparam int UI_PLAYRECORDING = 9;
    localparam int UI_CHANNELS      = 10;

    typedef enum logic [1:0] {
        ST_RELEASED        = 2'd0,
        ST_PRESS_PENDING   = 2'd1,
        ST_PRESSED         = 2'd2,
        ST_RELEASE_PENDING = 2'd3
    } ui_debounce_state_t;

    // Bits needed for a counter that must hold values 0..max_value (at least 1).
    function automatic int ui_cnt_width(input int max_value);
        return (max_value < 2) ? 1 : $clog2(max_value + 1);
    endfunction

endpackage

// File: rtl/ui_debounce_channel.sv
// One debounce channel: two-flop synchroniser, four-state debounce FSM,
// debounce counter, ms-tick hold counter and (with UI_DEBOUNCE_AUTOREPEAT_EN
// defined) the auto-repeat counter. Without the macro repeat_o is tied to 0.
module ui_debounce_channel
    import ui_input_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int HOLD_MS         = 500,
    parameter int REPEAT_MS       = 100,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic raw_i,
    input  logic tick_i,
    output logic level_o,
    output logic level_next_o,
    output logic pressed_o,
    output logic released_o,
    output logic held_o,
    output logic repeat_o
);

    localparam logic INACTIVE = (ACTIVE_LOW != 0);
    localparam int   DB_W     = ui_cnt_width(DEBOUNCE_CYCLES - 1);
    localparam int   HOLD_W   = ui_cnt_width(HOLD_MS);
    localparam logic [DB_W-1:0]   DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_MS);
    localparam logic [HOLD_W-1:0] HOLD_PRE = HOLD_W'(HOLD_MS - 1);

    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("ui_debounce_channel: DEBOUNCE_CYCLES must be at least 1");
    end
    if (HOLD_MS < 1 || REPEAT_MS < 1) begin : g_bad_hold
        $error("ui_debounce_channel: HOLD_MS and REPEAT_MS must be at least 1");
    end

    logic               sync1_q, sync2_q;
    logic               s;
    ui_debounce_state_t state_q, state_d;
    logic [DB_W-1:0]    db_q, db_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic               level_q, level_d;
    logic               pressed_q, pressed_d;
    logic               released_q, released_d;
    logic               held_q, held_d;
    logic               in_hold;

    // Normalised sample: 1 means the button is pressed regardless of pin polarity
    assign s       = (ACTIVE_LOW != 0) ? ~sync2_q : sync2_q;
    assign in_hold = (state_q == ST_PRESSED) || (state_q == ST_RELEASE_PENDING);

    // Two-flop synchroniser; reset loads the idle pin level so no false press follows reset
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            sync1_q <= INACTIVE;
            sync2_q <= INACTIVE;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
        end
    end

    // Debounce FSM plus hold counter; accepted press/release always clear hold progress
    always_comb begin
        state_d    = state_q;
        db_d       = db_q;
        level_d    = level_q;
        pressed_d  = 1'b0;
        released_d = 1'b0;
        hold_d     = hold_q;
        held_d     = 1'b0;
        case (state_q)
            ST_RELEASED: begin
                if (s) begin
                    state_d = ST_PRESS_PENDING;
                    db_d    = '0;
                end
            end
            ST_PRESS_PENDING: begin
                if (!s) begin
                    state_d = ST_RELEASED;
                end else if (db_q == DB_LAST) begin
                    state_d   = ST_PRESSED;
                    level_d   = 1'b1;
                    pressed_d = 1'b1;
                end else begin
                    db_d = db_q + 1'b1;
                end
            end
            ST_PRESSED: begin
                if (!s) begin
                    state_d = ST_RELEASE_PENDING;
                    db_d    = '0;
                end
            end
            ST_RELEASE_PENDING: begin
                if (s) begin
                    state_d = ST_PRESSED;
                end else if (db_q == DB_LAST) begin
                    state_d    = ST_RELEASED;
                    level_d    = 1'b0;
                    released_d = 1'b1;
                end else begin
                    db_d = db_q + 1'b1;
                end
            end
            default: state_d = ST_RELEASED;
        endcase

        // A release that completes on a tick edge wins, so held never coincides with released
        if (pressed_d || released_d) begin
            hold_d = '0;
        end else if (tick_i && in_hold && (hold_q != HOLD_MAX)) begin
            hold_d = hold_q + 1'b1;
            held_d = (hold_q == HOLD_PRE);
        end
    end

    // FSM, counters and registered outputs
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q    <= ST_RELEASED;
            db_q       <= '0;
            hold_q     <= '0;
            level_q    <= 1'b0;
            pressed_q  <= 1'b0;
            released_q <= 1'b0;
            held_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            db_q       <= db_d;
            hold_q     <= hold_d;
            level_q    <= level_d;
            pressed_q  <= pressed_d;
            released_q <= released_d;
            held_q     <= held_d;
        end
    end

`ifdef UI_DEBOUNCE_AUTOREPEAT_EN
    localparam int REP_W = ui_cnt_width(REPEAT_MS - 1);
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_MS - 1);

    logic [REP_W-1:0] rep_q, rep_d;
    logic             repeat_q, repeat_d;

    // Repeat phase restarts at the held pulse; pulses only while steadily pressed
    always_comb begin
        rep_d    = rep_q;
        repeat_d = 1'b0;
        if (pressed_d || released_d) begin
            rep_d = '0;
        end else if (held_d) begin
            rep_d    = '0;
            repeat_d = (state_q == ST_PRESSED);
        end else if (tick_i && in_hold && (hold_q == HOLD_MAX)) begin
            if (rep_q == REP_LAST) begin
                rep_d    = '0;
                repeat_d = (state_q == ST_PRESSED);
            end else begin
                rep_d = rep_q + 1'b1;
            end
        end
    end

    // Repeat counter and pulse register
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            rep_q    <= '0;
            repeat_q <= 1'b0;
        end else begin
            rep_q    <= rep_d;
            repeat_q <= repeat_d;
        end
    end

    assign repeat_o = repeat_q;
`else
    assign repeat_o = 1'b0;
`endif

    assign level_o      = level_q;
    assign level_next_o = level_d;
    assign pressed_o    = pressed_q;
    assign released_o   = released_q;
    assign held_o       = held_q;

endmodule

// File: rtl/ui_input_debounce_bank.sv
// Multi-channel debounce bank: shared ms-tick prescaler, one debounce channel
// per input and a registered anyPressed. Optional auto-repeat is enabled by
// defining UI_DEBOUNCE_AUTOREPEAT_EN; otherwise outputRepeat stays 0.
module ui_input_debounce_bank
    import ui_input_pkg::*;
#(
    parameter int CHANNELS    = UI_CHANNELS,
    parameter int CLOCK_HZ    = 50000000,
    parameter int DEBOUNCE_US = 1000,
    parameter int HOLD_MS     = 500,
    parameter int ACTIVE_LOW  = 1,
    parameter int REPEAT_MS   = 100
) (
    input  logic                clock_50Mhz,
    input  logic                reset_n,
    input  logic [CHANNELS-1:0] inputWires,
    output logic [CHANNELS-1:0] outputLevel,
    output logic [CHANNELS-1:0] outputPressed,
    output logic [CHANNELS-1:0] outputReleased,
    output logic [CHANNELS-1:0] outputHeld,
    output logic [CHANNELS-1:0] outputRepeat,
    output logic                anyPressed
);

    localparam int DEBOUNCE_CYCLES = CLOCK_HZ / 1000000 * DEBOUNCE_US;
    localparam int TICK_CYCLES     = CLOCK_HZ / 1000;
    localparam int PRESC_W         = ui_cnt_width(TICK_CYCLES - 1);
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("ui_input_debounce_bank: DEBOUNCE_CYCLES evaluates to 0");
    end
    if (TICK_CYCLES < 1 || CHANNELS < 1) begin : g_bad_config
        $error("ui_input_debounce_bank: CLOCK_HZ below 1 kHz or CHANNELS below 1");
    end

    logic [PRESC_W-1:0]  presc_q, presc_d;
    logic                tick_q;
    logic                any_q;
    logic [CHANNELS-1:0] level_next;

    // Free-running prescaler wraps every TICK_CYCLES cycles
    always_comb begin
        presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + 1'b1;
    end

    // Prescaler state and the one-cycle ms tick shared by every channel
    always_ff @(posedge clock_50Mhz) begin
        if (!reset_n) begin
            presc_q <= '0;
            tick_q  <= 1'b0;
        end else begin
            presc_q <= presc_d;
            tick_q  <= (presc_q == PRESC_LAST);
        end
    end

    // anyPressed is built from the channels' next levels so it updates on the same edge
    always_ff @(posedge clock_50Mhz) begin
        if (!reset_n) begin
            any_q <= 1'b0;
        end else begin
            any_q <= |level_next;
        end
    end

    assign anyPressed = any_q;

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
            ui_debounce_channel #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .HOLD_MS         (HOLD_MS),
                .REPEAT_MS       (REPEAT_MS),
                .ACTIVE_LOW      (ACTIVE_LOW)
            ) u_chan (
                .clk_i        (clock_50Mhz),
                .rst_n_i      (reset_n),
                .raw_i        (inputWires[gi]),
                .tick_i       (tick_q),
                .level_o      (outputLevel[gi]),
                .level_next_o (level_next[gi]),
                .pressed_o    (outputPressed[gi]),
                .released_o   (outputReleased[gi]),
                .held_o       (outputHeld[gi]),
                .repeat_o     (outputRepeat[gi])
            );
        end
    endgenerate

endmodule
